// File: rtl/mac_serial_pkg.sv
// Shared types and helpers for the multibit-serial MAC: FSM states and the
// precision-to-chunk-count rule used by both the controller and the datapath checks.
package mac_serial_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, FLUSH} state_t;

    localparam int CFG_MAX = 8;

    // Each set config bit halves the active weight width; never fewer than one chunk.
    function automatic int act_chunks(input logic [CFG_MAX-1:0] cfg,
                                      input int w_width, input int n_width);
        int pop;
        int nc;
        pop = 0;
        for (int i = 0; i < CFG_MAX; i++) pop += int'(cfg[i]);
        nc = (w_width >> pop) / n_width;
        return (nc < 1) ? 1 : nc;
    endfunction

    function automatic logic is_thermo(input logic [CFG_MAX-1:0] cfg);
        return (cfg & (cfg + CFG_MAX'(1))) == '0;
    endfunction

endpackage

// File: rtl/mac_serial_slicer.sv
// Weight chunk mux: picks the cnt-th N_WIDTH-bit slice of the held weight, LSB first.
module mac_serial_slicer #(
    parameter int W_WIDTH = 8,
    parameter int N_WIDTH = 2,
    parameter int CNT_W   = 2
) (
    input  logic [W_WIDTH-1:0] w_reg,
    input  logic [CNT_W-1:0]   cnt,
    output logic [N_WIDTH-1:0] chunk
);
    localparam int NCH = W_WIDTH / N_WIDTH;

    logic [NCH-1:0][N_WIDTH-1:0] w_chunks;

    assign w_chunks = w_reg[NCH*N_WIDTH-1:0];

    always_comb begin
        chunk = '0;
        for (int i = 0; i < NCH; i++)
            if (cnt == CNT_W'(i)) chunk = w_chunks[i];
    end

endmodule

// File: rtl/mac_serial_ctrl.sv
// Drive side of the multibit-serial MAC: accepts (weight, activation) pairs, issues
// weight chunks LSB-first and sequences fsm_accu/fsm_last/accu_en/mac_clr/z_valid.
module mac_serial_ctrl
    import mac_serial_pkg::*;
#(
    parameter int W_WIDTH        = 8,
    parameter int A_WIDTH        = 8,
    parameter int N_WIDTH        = 2,
    parameter int CONFIG_W_WIDTH = 2,
    parameter int PLUS_WIDTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CONFIG_W_WIDTH-1:0] config_w,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W_WIDTH-1:0]        in_w,
    input  logic [A_WIDTH-1:0]        in_a,
    input  logic                      in_last,
    output logic [N_WIDTH-1:0]        w_serial,
    output logic [A_WIDTH-1:0]        a,
    output logic                      fsm_accu,
    output logic                      fsm_last,
    output logic                      accu_en,
    output logic                      mac_clr,
    output logic                      z_valid,
    output logic                      acc_ovf,
    output logic                      cfg_err
);
    localparam int NCH   = W_WIDTH / N_WIDTH;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ACC_W = PLUS_WIDTH + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(1) << PLUS_WIDTH;

    state_t                    state, state_nxt;
    logic [W_WIDTH-1:0]        w_reg;
    logic [A_WIDTH-1:0]        a_reg;
    logic                      last_reg;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          last_cnt;
    logic [CONFIG_W_WIDTH-1:0] cfg_reg;
    logic                      first_reg;
    logic [ACC_W-1:0]          acc_cnt;
    logic [N_WIDTH-1:0]        chunk;
    logic                      final_chunk;
    logic                      accept;

    mac_serial_slicer #(
        .W_WIDTH (W_WIDTH),
        .N_WIDTH (N_WIDTH),
        .CNT_W   (CNT_W)
    ) u_slicer (
        .w_reg (w_reg),
        .cnt   (cnt),
        .chunk (chunk)
    );

    always_comb begin
        last_cnt = CNT_W'(act_chunks(CFG_MAX'(cfg_reg), W_WIDTH, N_WIDTH) - 1);
    end

    assign final_chunk = (state == SHIFT) && (cnt == last_cnt);
    assign accept      = in_valid & in_ready;
    assign w_serial    = (state == SHIFT) ? chunk : '0;
    assign a           = a_reg;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        fsm_accu  = 1'b0;
        fsm_last  = 1'b0;
        z_valid   = 1'b0;
        mac_clr   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                fsm_accu = (cnt == '0);
                fsm_last = final_chunk;
                // Accepting on the final chunk keeps back-to-back items bubble-free.
                in_ready = final_chunk & ~last_reg;
                if (final_chunk) state_nxt = (in_valid & ~last_reg) ? SHIFT : DRAIN;
            end
            DRAIN: begin
                if (last_reg) begin
                    state_nxt = FLUSH;
                end else begin
                    in_ready  = 1'b1;
                    state_nxt = in_valid ? SHIFT : IDLE;
                end
            end
            FLUSH: begin
                z_valid   = 1'b1;
                mac_clr   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            w_reg     <= '0;
            a_reg     <= '0;
            last_reg  <= 1'b0;
            cnt       <= '0;
            cfg_reg   <= '0;
            first_reg <= 1'b1;
            acc_cnt   <= '0;
            accu_en   <= 1'b0;
            acc_ovf   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state   <= state_nxt;
            // z picks up the finished product one edge after its final chunk.
            accu_en <= final_chunk;
            if (accept) begin
                w_reg     <= in_w;
                a_reg     <= in_a;
                last_reg  <= in_last;
                cnt       <= '0;
                first_reg <= 1'b0;
                if (first_reg) begin
                    cfg_reg <= config_w;
                    if (!is_thermo(CFG_MAX'(config_w))) cfg_err <= 1'b1;
                end
                if (acc_cnt == ACC_MAX) acc_ovf <= 1'b1;
                else                    acc_cnt <= acc_cnt + ACC_W'(1);
            end else if ((state == SHIFT) && !final_chunk) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == FLUSH) begin
                acc_cnt   <= '0;
                first_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_serial_ctrl.sv
// Directed bench for mac_serial_ctrl with a behavioural signed MAC model driven
// by the controller outputs; z is compared against hand-computed dot products.
module tb_mac_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] config_w;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_w;
    logic [7:0] in_a;
    logic       in_last;
    logic [1:0] w_serial;
    logic [7:0] a;
    logic       fsm_accu, fsm_last, accu_en, mac_clr, z_valid, acc_ovf, cfg_err;

    int n_vec = 0;
    int n_err = 0;

    mac_serial_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .config_w (config_w),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_w     (in_w),
        .in_a     (in_a),
        .in_last  (in_last),
        .w_serial (w_serial),
        .a        (a),
        .fsm_accu (fsm_accu),
        .fsm_last (fsm_last),
        .accu_en  (accu_en),
        .mac_clr  (mac_clr),
        .z_valid  (z_valid),
        .acc_ovf  (acc_ovf),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    // MAC model: snapshot controls mid-cycle, apply them at the next rising edge.
    logic       s_rst = 1'b1, s_accu = 1'b0, s_last = 1'b0, s_en = 1'b0, s_clr = 1'b0;
    logic [1:0] s_w = '0;
    logic [7:0] s_a = '0;
    int         mz = 0, mult = 0, k = 0;

    function automatic int chunk_val(input logic [1:0] c, input logic sgn);
        return sgn ? int'($signed(c)) : int'(c);
    endfunction

    always @(negedge clk) begin
        s_rst  <= rst;
        s_accu <= fsm_accu;
        s_last <= fsm_last;
        s_en   <= accu_en;
        s_clr  <= mac_clr;
        s_w    <= w_serial;
        s_a    <= a;
    end

    always @(posedge clk) begin
        if (s_rst || s_clr) begin
            mz   <= 0;
            mult <= 0;
            k    <= 0;
        end else begin
            if (s_en) mz <= mz + mult;
            k    <= s_accu ? 1 : ((k < 15) ? k + 1 : k);
            mult <= (s_accu ? 0 : mult)
                    + chunk_val(s_w, s_last) * int'(s_a) * (1 << (2 * (s_accu ? 0 : k)));
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] w, input logic [7:0] av, input logic lst,
                        output int waited);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_w     = w;
        in_a     = av;
        in_last  = lst;
        while (n < 50) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        chk("send_ready", in_ready, 1);
        waited = n;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_z(input string tag, input int exp, output int lat);
        int n;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            if (z_valid) break;
            n++;
        end
        lat = n;
        chk({tag, "_zv"}, z_valid, 1);
        chk({tag, "_z"}, mz, exp);
        chk({tag, "_clr"}, mac_clr, 1);
        chk({tag, "_rdy"}, in_ready, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int         w, lat;
        logic [1:0] t1_w [4];
        t1_w[0] = 2'b01; t1_w[1] = 2'b11; t1_w[2] = 2'b11; t1_w[3] = 2'b11;

        rst = 1'b1; config_w = 2'b00; in_valid = 1'b0;
        in_w = '0; in_a = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_wser", w_serial, 0);
        chk("rst_a", a, 0);
        chk("rst_flags", {fsm_accu, fsm_last, accu_en, mac_clr, z_valid, acc_ovf, cfg_err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: full precision, -3 * 5, cycle-exact control sequence
        config_w = 2'b00;
        send(8'hFD, 8'd5, 1'b1, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_wser", w_serial, t1_w[i]);
            chk("t1_accu", fsm_accu, (i == 0));
            chk("t1_last", fsm_last, (i == 3));
            chk("t1_en", accu_en, 0);
            chk("t1_a", a, 5);
        end
        @(negedge clk);
        chk("t1_drain_en", accu_en, 1);
        chk("t1_drain_zv", z_valid, 0);
        @(negedge clk);
        chk("t1_zv", z_valid, 1);
        chk("t1_clr", mac_clr, 1);
        chk("t1_z", mz, -15);
        @(negedge clk);
        chk("t1_idle_rdy", in_ready, 1);
        chk("t1_z_cleared", mz, 0);
        chk("t1_cfg_err", cfg_err, 0);
        @(posedge clk); #1;

        // 2: half precision, 2 chunks, -6 * 3
        config_w = 2'b01;
        send(8'h0A, 8'd3, 1'b1, w);
        @(negedge clk);
        chk("t2_w0", w_serial, 2);
        chk("t2_c0", {fsm_accu, fsm_last}, 2'b10);
        @(negedge clk);
        chk("t2_w1", w_serial, 2);
        chk("t2_c1", {fsm_accu, fsm_last}, 2'b01);
        wait_z("t2", -18, lat);

        // 3: quarter precision, one item per cycle, 4 x (-1 * 7)
        config_w = 2'b11;
        for (int i = 0; i < 4; i++) begin
            send(8'h03, 8'd7, (i == 3), w);
            chk("t3_nobubble", w, 0);
        end
        wait_z("t3", -28, lat);
        chk("t3_lat", lat, 2);

        // 4: gapped valid, second pair taken in DRAIN, third from IDLE
        config_w = 2'b00;
        send(8'd1, 8'd10, 1'b0, w);
        repeat (4) @(posedge clk); #1;
        send(8'd2, 8'd20, 1'b0, w);
        chk("t4_drain_acc", w, 0);
        repeat (6) @(posedge clk); #1;
        send(8'hFF, 8'd30, 1'b1, w);
        wait_z("t4", 20, lat);
        chk("t4_ovf", acc_ovf, 0);

        // 5: reset during chunk 2 drops the item
        send(8'h55, 8'd9, 1'b1, w);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_rdy", in_ready, 1);
        chk("t5_wser", w_serial, 0);
        chk("t5_a", a, 0);
        chk("t5_flags", {fsm_accu, fsm_last, accu_en, mac_clr, z_valid}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'd3, 8'd4, 1'b1, w);
        wait_z("t5", 12, lat);

        // 6: 17 pairs overflow the headroom; non-thermometer config
        config_w = 2'b10;
        for (int i = 0; i < 17; i++) begin
            send(8'd1, 8'd1, (i == 16), w);
            if (i == 0)  chk("t6_cfg_err", cfg_err, 1);
            if (i == 15) chk("t6_ovf_16", acc_ovf, 0);
            if (i == 16) chk("t6_ovf_17", acc_ovf, 1);
        end
        wait_z("t6", 17, lat);
        chk("t6_ovf_sticky", acc_ovf, 1);
        chk("t6_err_sticky", cfg_err, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_ovf_rst", acc_ovf, 0);
        chk("t6_err_rst", cfg_err, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
